// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: single-clock AXI4-Stream FIFO with a registered output
// stage and an optional store-and-forward packet mode.
module axis_packet_fifo #(
  parameter int TDATA_WIDTH = 4,
  parameter int TUSER_WIDTH = 1,
  parameter int DEPTH       = 512,
  parameter int PACKET_MODE = 0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [TDATA_WIDTH*8-1:0] s_axis_tdata,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic [TUSER_WIDTH-1:0]   s_axis_tuser,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [TDATA_WIDTH*8-1:0] m_axis_tdata,
  output logic [TDATA_WIDTH-1:0]   m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic [$clog2(DEPTH):0]   pkt_count
);

  localparam int DW = TDATA_WIDTH * 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = DW + TDATA_WIDTH + 1 + TUSER_WIDTH;
  localparam int LB = TUSER_WIDTH;
  localparam int KB = TUSER_WIDTH + 1;
  localparam int DB = TUSER_WIDTH + 1 + TDATA_WIDTH;

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [AW-1:0] A_ONE   = AW'(1);

  typedef enum logic {
    ST_HOLD,
    ST_REL
  } rel_state_t;

  logic [MW-1:0] r_mem [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_fill;
  logic [CW-1:0] r_ram_cnt;
  logic [CW-1:0] r_pkts;
  logic          r_s_ready;
  logic          r_m_valid;
  logic [MW-1:0] r_m_beat;
  rel_state_t    r_state;

  logic          w_wr;
  logic          w_rd;
  logic          w_load;
  logic          w_ram_ne;
  logic          w_m_last;
  logic          w_out_last;
  logic          w_elig;
  logic [CW-1:0] w_ram_pkts;
  logic [CW-1:0] w_fill_nxt;
  logic [CW-1:0] w_ram_cnt_nxt;
  logic [CW-1:0] w_pkts_nxt;
  rel_state_t    w_state_nxt;

  assign w_wr       = s_axis_tvalid && r_s_ready;
  assign w_rd       = r_m_valid && m_axis_tready;
  assign w_ram_ne   = (r_ram_cnt != '0);
  assign w_m_last   = r_m_beat[LB];
  assign w_out_last = r_m_valid && w_m_last;
  assign w_load     = w_elig && (!r_m_valid || m_axis_tready);

  assign s_axis_tready = r_s_ready;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tdata  = r_m_beat[DB +: DW];
  assign m_axis_tkeep  = r_m_beat[KB +: TDATA_WIDTH];
  assign m_axis_tlast  = w_m_last;
  assign m_axis_tuser  = r_m_beat[0 +: TUSER_WIDTH];
  assign fill_count    = r_fill;
  assign pkt_count     = r_pkts;

  // Eligibility: packets still in RAM exclude a tlast already in the
  // output register; release stops once the long packet's tlast is loaded.
  always_comb begin
    w_ram_pkts = r_pkts;
    if (w_out_last) begin
      w_ram_pkts = r_pkts - C_ONE;
    end
    w_elig = w_ram_ne;
    if (PACKET_MODE != 0) begin
      w_elig = w_ram_ne &&
               ((w_ram_pkts != '0) ||
                (r_state == ST_REL && !w_out_last));
    end
  end

  // Next values of the occupancy and packet counters.
  always_comb begin
    w_fill_nxt    = r_fill;
    w_ram_cnt_nxt = r_ram_cnt;
    w_pkts_nxt    = r_pkts;
    if (w_wr && !w_rd) begin
      w_fill_nxt = r_fill + C_ONE;
    end else if (!w_wr && w_rd) begin
      w_fill_nxt = r_fill - C_ONE;
    end
    if (w_wr && !w_load) begin
      w_ram_cnt_nxt = r_ram_cnt + C_ONE;
    end else if (!w_wr && w_load) begin
      w_ram_cnt_nxt = r_ram_cnt - C_ONE;
    end
    if ((w_wr && s_axis_tlast) && !(w_rd && w_m_last)) begin
      w_pkts_nxt = r_pkts + C_ONE;
    end else if (!(w_wr && s_axis_tlast) && (w_rd && w_m_last)) begin
      w_pkts_nxt = r_pkts - C_ONE;
    end
  end

  // Forced-release FSM: a full FIFO with no complete packet drains
  // cut-through until the oversize packet's tlast leaves.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_HOLD: begin
        if (PACKET_MODE != 0 && r_fill == C_DEPTH && r_pkts == '0) begin
          w_state_nxt = ST_REL;
        end
      end
      ST_REL: begin
        if (w_rd && w_m_last) begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: w_state_nxt = ST_HOLD;
    endcase
  end

  // Release state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pointers, counters and the registered slave ready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_fill    <= '0;
      r_ram_cnt <= '0;
      r_pkts    <= '0;
      r_s_ready <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + A_ONE;
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + A_ONE;
      end
      r_fill    <= w_fill_nxt;
      r_ram_cnt <= w_ram_cnt_nxt;
      r_pkts    <= w_pkts_nxt;
      r_s_ready <= (w_fill_nxt < C_DEPTH);
    end
  end

  // Beat storage; simple dual-port, written from the slave side.
  always_ff @(posedge aclk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {s_axis_tdata, s_axis_tkeep,
                          s_axis_tlast, s_axis_tuser};
    end
  end

  // Output register: synchronous RAM read, held while stalled downstream.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_valid <= 1'b0;
      r_m_beat  <= '0;
    end else begin
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_beat  <= r_mem[r_rd_ptr];
      end else if (w_rd) begin
        r_m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb_axis_packet_fifo: scoreboard bench for a cut-through instance (0)
// and a store-and-forward instance (1), both 16 beats deep.
module tb_axis_packet_fifo;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic [0:0]  u;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  logic [1:0]       sv, sr, sl, mv, mr, ml;
  logic [1:0][31:0] sd, md;
  logic [1:0][3:0]  sk, mk;
  logic [1:0][0:0]  su, mu;
  logic [1:0][4:0]  fc, pc;

  axis_packet_fifo #(
    .TDATA_WIDTH(4), .TUSER_WIDTH(1), .DEPTH(16), .PACKET_MODE(0)
  ) u_ct (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(sv[0]), .s_axis_tready(sr[0]),
    .s_axis_tdata(sd[0]), .s_axis_tkeep(sk[0]),
    .s_axis_tlast(sl[0]), .s_axis_tuser(su[0]),
    .m_axis_tvalid(mv[0]), .m_axis_tready(mr[0]),
    .m_axis_tdata(md[0]), .m_axis_tkeep(mk[0]),
    .m_axis_tlast(ml[0]), .m_axis_tuser(mu[0]),
    .fill_count(fc[0]), .pkt_count(pc[0])
  );

  axis_packet_fifo #(
    .TDATA_WIDTH(4), .TUSER_WIDTH(1), .DEPTH(16), .PACKET_MODE(1)
  ) u_sf (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(sv[1]), .s_axis_tready(sr[1]),
    .s_axis_tdata(sd[1]), .s_axis_tkeep(sk[1]),
    .s_axis_tlast(sl[1]), .s_axis_tuser(su[1]),
    .m_axis_tvalid(mv[1]), .m_axis_tready(mr[1]),
    .m_axis_tdata(md[1]), .m_axis_tkeep(mk[1]),
    .m_axis_tlast(ml[1]), .m_axis_tuser(mu[1]),
    .fill_count(fc[1]), .pkt_count(pc[1])
  );

  beat_t q_c[$];
  beat_t q_s[$];
  int errs = 0;
  int chks = 0;

  logic [1:0] stall;
  beat_t      held [2];
  int         outn [2];
  int         first [2];
  int         last [2];
  int         fmax [2];
  bit         done;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mon(int i);
    beat_t o;
    beat_t e;
    int n;
    o.d = md[i]; o.k = mk[i]; o.l = ml[i]; o.u = mu[i];
    if (stall[i]) chk($sformatf("hold%0d", i), {mv[i], o}, {1'b1, held[i]});
    if (mv[i] && mr[i]) begin
      n = (i == 0) ? q_c.size() : q_s.size();
      if (n == 0) begin
        chks++; errs++;
        $display("FAIL extra%0d: got %0h want none", i, o);
      end else begin
        if (i == 0) e = q_c.pop_front();
        else e = q_s.pop_front();
        chk($sformatf("data%0d", i), o, e);
      end
      outn[i]++;
      if (outn[i] == 1) first[i] = cyc;
      last[i] = cyc;
    end
    if (int'(fc[i]) > fmax[i]) fmax[i] = int'(fc[i]);
    stall[i] = mv[i] && !mr[i];
    held[i] = o;
  endtask

  always @(negedge aclk) begin
    if (!aresetn) stall = 2'b00;
    else begin
      mon(0);
      mon(1);
    end
  end

  task automatic drive(int i, logic [31:0] d, logic l);
    sv[i] = 1'b1; sd[i] = d; sk[i] = d[7:4]; sl[i] = l; su[i] = d[1];
  endtask

  task automatic send(int i, logic [31:0] d, logic l);
    beat_t b;
    bit ok;
    ok = 0;
    b.d = d; b.k = d[7:4]; b.l = l; b.u = d[1];
    drive(i, d, l);
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge aclk);
      if (sr[i]) begin
        ok = 1;
        if (i == 0) q_c.push_back(b);
        else q_s.push_back(b);
      end
      @(posedge aclk); #1;
    end
    sv[i] = 1'b0;
    if (!ok) begin
      chks++; errs++;
      $display("FAIL send%0d: got timeout want accept of %0h", i, d);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic drain(int i, int maxc);
    bit ok;
    ok = 0;
    for (int k = 0; k < maxc && !ok; k++) begin
      @(negedge aclk);
      if (!mv[i] && ((i == 0) ? q_c.size() : q_s.size()) == 0) ok = 1;
    end
    @(posedge aclk); #1;
    if (!ok) begin
      chks++; errs++;
      $display("FAIL drain%0d: got timeout want empty", i);
    end
  endtask

  initial begin
    int acc;
    int ce;
    done = 0;
    stall = 2'b00;
    for (int i = 0; i < 2; i++) begin
      outn[i] = 0; first[i] = 0; last[i] = 0; fmax[i] = 0;
    end
    sv = 2'b11; sd = '0; sk = '0; sl = '0; su = '0; mr = 2'b00;

    // reset hold with valid asserted
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_sready%0d", i), sr[i], 0);
      chk($sformatf("rst_mvalid%0d", i), mv[i], 0);
      chk($sformatf("rst_fill%0d", i), fc[i], 0);
      chk($sformatf("rst_pkt%0d", i), pc[i], 0);
      chk($sformatf("rst_mbeat%0d", i), {md[i], mk[i], ml[i], mu[i]}, 0);
    end
    aresetn = 1'b1;
    #1;
    chk("rel_sready_pre", sr, 2'b00);
    @(posedge aclk); #1;
    chk("rel_sready_post", sr, 2'b11);
    sv = 2'b00;
    idle(2);

    // cut-through stream, 100 beats at full rate
    mr[0] = 1'b1;
    outn[0] = 0; fmax[0] = 0;
    send(0, 32'h0, 1'b0);
    ce = cyc;
    for (int n = 1; n < 100; n++) send(0, n, (n % 10) == 9);
    drain(0, 50);
    chk("ct_first_lat", first[0], ce + 1);
    chk("ct_count", outn[0], 100);
    chk("ct_span", last[0] - first[0], 99);
    chk("ct_fillmax", fmax[0], 2);
    chk("ct_fill_end", fc[0], 0);
    chk("ct_pkt_end", pc[0], 0);

    // full and backpressure
    mr[0] = 1'b0;
    acc = 0;
    for (int n = 0; n < 20; n++) begin
      beat_t b;
      b.d = 32'h1000 + acc; b.k = b.d[7:4]; b.l = 1'b0; b.u = b.d[1];
      drive(0, b.d, 1'b0);
      @(negedge aclk);
      if (sr[0]) begin
        q_c.push_back(b);
        acc++;
      end
      @(posedge aclk); #1;
    end
    sv[0] = 1'b0;
    chk("full_acc", acc, 16);
    chk("full_fill", fc[0], 16);
    chk("full_sready", sr[0], 0);
    chk("full_mvalid", mv[0], 1);
    mr[0] = 1'b1;
    @(posedge aclk); #1;
    chk("bp_sready", sr[0], 1);
    chk("bp_fill", fc[0], 15);
    drain(0, 60);
    chk("bp_fill_end", fc[0], 0);

    // store-and-forward, 5 beats with gaps
    mr[1] = 1'b1;
    outn[1] = 0;
    for (int n = 0; n < 4; n++) begin
      send(1, 32'h200 + n, 1'b0);
      idle(2);
      chk($sformatf("sf_hold%0d", n), {mv[1], pc[1]}, 0);
    end
    send(1, 32'h204, 1'b1);
    chk("sf_pkt1", pc[1], 1);
    chk("sf_mv_pre", mv[1], 0);
    @(posedge aclk); #1;
    chk("sf_mv_post", mv[1], 1);
    drain(1, 30);
    chk("sf_count", outn[1], 5);
    chk("sf_span", last[1] - first[1], 4);
    chk("sf_pkt0", pc[1], 0);

    // oversize packet forces release
    outn[1] = 0;
    for (int n = 0; n < 16; n++) send(1, 32'h300 + n, 1'b0);
    chk("ov_fill", fc[1], 16);
    chk("ov_sready", sr[1], 0);
    chk("ov_mv_held", mv[1], 0);
    idle(3);
    chk("ov_release", mv[1], 1);
    for (int n = 16; n < 40; n++) send(1, 32'h300 + n, n == 39);
    drain(1, 100);
    chk("ov_count", outn[1], 40);
    chk("ov_pkt0", pc[1], 0);
    chk("ov_fill0", fc[1], 0);
    send(1, 32'h400, 1'b0);
    idle(2);
    chk("ov_next_hold0", mv[1], 0);
    send(1, 32'h401, 1'b0);
    idle(2);
    chk("ov_next_hold1", mv[1], 0);
    send(1, 32'h402, 1'b1);
    chk("ov_next_pkt", pc[1], 1);
    drain(1, 30);
    chk("ov_next_pkt0", pc[1], 0);

    // random valid/ready with a mid-packet reset
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          while ($urandom_range(0, 99) >= 30) begin
            @(posedge aclk); #1;
          end
          send(0, 32'h5000 + n, (n % 5) == 4);
          if (n == 60) begin
            aresetn = 1'b0;
            q_c.delete();
            @(negedge aclk);
            chk("rnd_rst_mv", mv[0], 0);
            chk("rnd_rst_fill", fc[0], 0);
            @(posedge aclk); #1;
            aresetn = 1'b1;
            @(posedge aclk); #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge aclk); #1;
          mr[0] = ($urandom_range(0, 99) < 70);
        end
      end
    join
    mr[0] = 1'b1;
    drain(0, 300);
    chk("rnd_fill_end", fc[0], 0);
    chk("rnd_pkt_end", pc[0], 0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
